// File: rtl/rgb_pwm_pkg.sv
// Shared types and constants for the RGB PWM fader: FSM states, default
// parameters and the 8-bit gamma table used when RGB_PWM_FADER_GAMMA_EN is set.
package rgb_pwm_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StFade
   } state_e;

   localparam int unsigned DefPwmBits = 8;
   localparam int unsigned DefFadeDiv = 1024;

   // Monotonic perceptual curve; endpoints pinned so full off/on are preserved.
   localparam logic [7:0] GammaLut [256] = '{
        0,   0,   0,   0,   0,   0,   0,   0,   0,   0,   0,   0,   0,   0,   0,   0,
        0,   0,   0,   0,   0,   0,   0,   0,   0,   0,   0,   0,   1,   1,   1,   1,
        1,   1,   1,   1,   1,   1,   1,   1,   1,   2,   2,   2,   2,   2,   2,   2,
        2,   3,   3,   3,   3,   3,   3,   3,   4,   4,   4,   4,   4,   5,   5,   5,
        5,   6,   6,   6,   6,   7,   7,   7,   7,   8,   8,   8,   9,   9,   9,  10,
       10,  10,  11,  11,  11,  12,  12,  13,  13,  13,  14,  14,  15,  15,  16,  16,
       17,  17,  18,  18,  19,  19,  20,  20,  21,  21,  22,  22,  23,  24,  24,  25,
       25,  26,  27,  27,  28,  29,  29,  30,  31,  32,  32,  33,  34,  35,  35,  36,
       37,  38,  39,  39,  40,  41,  42,  43,  44,  45,  46,  47,  48,  49,  50,  50,
       51,  52,  54,  55,  56,  57,  58,  59,  60,  61,  62,  63,  64,  66,  67,  68,
       69,  70,  72,  73,  74,  75,  77,  78,  79,  81,  82,  83,  85,  86,  87,  89,
       90,  92,  93,  95,  96,  98,  99, 101, 102, 104, 105, 107, 109, 110, 112, 114,
      115, 117, 119, 120, 122, 124, 126, 127, 129, 131, 133, 135, 137, 138, 140, 142,
      144, 146, 148, 150, 152, 154, 156, 158, 160, 162, 164, 167, 169, 171, 173, 175,
      177, 180, 182, 184, 186, 189, 191, 193, 196, 198, 200, 203, 205, 208, 210, 213,
      215, 218, 220, 223, 225, 228, 231, 233, 236, 239, 241, 244, 247, 249, 252, 255
   };

endpackage

// File: rtl/rgb_gamma_lut.sv
// Combinational 8-bit gamma ROM backed by the package table.
module rgb_gamma_lut
   import rgb_pwm_pkg::*;
(
   input  logic [7:0] idx_i,
   output logic [7:0] val_o
);

   always_comb begin
      val_o = GammaLut[idx_i];
   end

endmodule

// File: rtl/rgb_pwm_fader.sv
// Three-channel LED PWM with linear colour fading and period-aligned duty updates.
// Define RGB_PWM_FADER_GAMMA_EN to map duties through the gamma LUT (PWM_BITS must be 8).
module rgb_pwm_fader
   import rgb_pwm_pkg::*;
#(
   parameter int unsigned PWM_BITS = DefPwmBits,
   parameter int unsigned FADE_DIV = DefFadeDiv
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [PWM_BITS-1:0] cmd_r,
   input  logic [PWM_BITS-1:0] cmd_g,
   input  logic [PWM_BITS-1:0] cmd_b,
   output logic                busy,
   output logic                led_r,
   output logic                led_g,
   output logic                led_b
);

   localparam int unsigned PreW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
   localparam logic [PreW-1:0] PreMax = PreW'(FADE_DIV - 1);
   localparam logic [PWM_BITS-1:0] CntMax = '1;

   // Channel index 0 = red, 1 = green, 2 = blue.
   state_e                     state_q, state_d;
   logic [2:0][PWM_BITS-1:0]   cur_q, cur_d;
   logic [2:0][PWM_BITS-1:0]   tgt_q, tgt_d;
   logic [2:0][PWM_BITS-1:0]   duty_q, duty_d;
   logic [2:0][PWM_BITS-1:0]   duty_src;
   logic [2:0][PWM_BITS-1:0]   cur_step;
   logic [2:0][PWM_BITS-1:0]   cmd;
   logic [PWM_BITS-1:0]        cnt_q, cnt_d;
   logic [PreW-1:0]            pre_q, pre_d;
   logic [2:0]                 led_q, led_d;
   logic                       fade_tick;

   assign cmd = {cmd_b, cmd_g, cmd_r};

`ifdef RGB_PWM_FADER_GAMMA_EN
   if (PWM_BITS != 8) begin : g_bad_width
      $error("rgb_pwm_fader: gamma LUT requires PWM_BITS == 8");
   end

   for (genvar c = 0; c < 3; c++) begin : g_gamma
      rgb_gamma_lut u_lut (
         .idx_i (cur_q[c]),
         .val_o (duty_src[c])
      );
   end
`else
   assign duty_src = cur_q;
`endif

   assign fade_tick = (state_q == StFade) && (pre_q == PreMax);

   // One LSB toward target; equality holds, so no overshoot or wrap.
   always_comb begin
      cur_step = cur_q;
      for (int c = 0; c < 3; c++) begin
         if (cur_q[c] < tgt_q[c]) begin
            cur_step[c] = cur_q[c] + 1'b1;
         end else if (cur_q[c] > tgt_q[c]) begin
            cur_step[c] = cur_q[c] - 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      cur_d   = cur_q;
      pre_d   = pre_q;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               tgt_d = cmd;
               pre_d = '0;
               if (cmd != cur_q) begin
                  state_d = StFade;
               end
            end
         end
         StFade: begin
            if (fade_tick) begin
               pre_d = '0;
               cur_d = cur_step;
               if (cur_step == tgt_q) begin
                  state_d = StIdle;
               end
            end else begin
               pre_d = pre_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign cmd_ready = (state_q == StIdle);
   assign busy      = (state_q == StFade);

   // Duty only reloads on the last count so a period is never cut short.
   always_comb begin
      cnt_d  = cnt_q + 1'b1;
      duty_d = (cnt_q == CntMax) ? duty_src : duty_q;
      for (int c = 0; c < 3; c++) begin
         led_d[c] = (cnt_q < duty_q[c]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cur_q   <= '0;
         tgt_q   <= '0;
         duty_q  <= '0;
         cnt_q   <= '0;
         pre_q   <= '0;
         led_q   <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         tgt_q   <= tgt_d;
         duty_q  <= duty_d;
         cnt_q   <= cnt_d;
         pre_q   <= pre_d;
         led_q   <= led_d;
      end
   end

   assign led_r = led_q[0];
   assign led_g = led_q[1];
   assign led_b = led_q[2];

endmodule
